mem_dump_tx: RTL and testbench
==============================

# mem_dump_tx

Serializes the five 32-bit data-memory snapshot words (`memoria0`..`memoria4`) into a framed byte stream for the UART transmitter. The block sits between the MEM-stage snapshot buffer and the UART TX core. On a start request it captures all five words and issues 22 bytes in order: header, 20 data bytes, XOR checksum. Each byte is handed to the UART through a start/done handshake.

## Interface
Parameters:
- `HEADER`, default 8'hA5: frame header byte, sent first and excluded from the checksum.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  dump request; sampled only in IDLE.
- `memoria0`..`memoria4`  in  32 each  snapshot words from the MEM-stage buffer.
- `tx_done`  in  1  one-cycle pulse from the UART TX core when the current byte has finished shifting out.
- `tx_data`  out  8  byte presented to the UART TX core.
- `tx_start`  out  1  one-cycle pulse; the UART TX core loads `tx_data` on this pulse.
- `busy`  out  1  high whenever the block is not in IDLE.
- `done`  out  1  one-cycle pulse after the checksum byte completes.

## Operation
- States:
  - IDLE: wait for `start`.
  - SEND: drive `tx_start` for one cycle.
  - WAIT: wait for `tx_done`.
  - FINISH: pulse `done` for one cycle.
- IDLE:
  - `start`=1 captures all five words into a 160-bit snapshot register.
  - Clears the byte index (0..21) and the checksum accumulator.
  - Next state is SEND.
- Byte order:
  - Index 0 is `HEADER`.
  - Indices 1..20 are word0..word4 from the snapshot, each word MSB first (bits 31:24, 23:16, 15:8, 7:0).
  - Index 21 is the checksum.
- SEND:
  - `tx_start`=1 and `tx_data` = byte[index].
  - For indices 1..20, the checksum is updated as checksum ^= byte[index].
  - Next state is always WAIT.
  - `tx_done` is ignored in SEND.
- WAIT:
  - `tx_data` holds its value.
  - `tx_done`=1 with index<21: increment the index and go to SEND.
  - `tx_done`=1 with index=21: go to FINISH.
- FINISH: `done`=1, next state IDLE.
- Checksum: 8-bit XOR of the 20 data bytes, taken from the snapshot rather than the live inputs.
- The live `memoria*` inputs are ignored outside the capture cycle. Changes mid-frame never affect transmitted bytes.
- `start` asserted while not in IDLE is ignored and is not queued.
- `start` held high continuously starts a new frame on the cycle after FINISH.
- `tx_done` asserted in IDLE or FINISH is ignored.

## Timing
- Reset values (async, immediate):
  - state IDLE, `tx_data`=8'h00, `tx_start`=0, `busy`=0, `done`=0.
  - Index 0, checksum 0, snapshot 0.
- Start latency: `start` high in cycle n (IDLE) gives `tx_start`=1 with `tx_data`=`HEADER` in cycle n+1.
- Byte advance: `tx_done` high in cycle m (WAIT) gives `tx_start` for the next byte in cycle m+1.
- Frame end: `tx_done` for the checksum byte in cycle m gives `done`=1 in cycle m+1 and `busy`=0 in cycle m+2.
- `busy` is 1 in SEND, WAIT and FINISH.
- `tx_start` is exactly 22 single-cycle pulses per frame, never in consecutive cycles.
- Minimum frame length with `tx_done` returned in the cycle after every `tx_start`: 1 + 22×2 = 45 cycles from `start` to `done`.
- Reset mid-frame aborts immediately with no partial `done`. The next `start` begins a new frame from the header.

## Test plan
- Basic frame:
  - Stimulus: memoria0=32'h11223344, memoria1=32'h55667788, memoria2..4=0, pulse `start`, and a bench UART model returning `tx_done` 3 cycles after each `tx_start`.
  - Required response: bytes A5,11,22,33,44,55,66,77,88, then twelve 00 bytes, then checksum 88. `done` pulses once and `busy` then falls.
- All-ones:
  - Stimulus: all words 32'hFFFFFFFF.
  - Required response: A5, twenty FF bytes, checksum 00.
- Snapshot isolation:
  - Stimulus: memoria0=32'hDEADBEEF at `start`, then memoria0 changed to 32'h0 after the header is sent.
  - Required response: bytes DE,AD,BE,EF are still transmitted and the checksum matches the captured data.
- Start while busy: a second `start` pulse during WAIT of byte 5 is ignored. Exactly 22 `tx_start` pulses and one `done` result.
- Reset mid-frame:
  - Stimulus: assert `reset` during WAIT of byte 7.
  - Required response: all outputs are 0 in the same cycle. A new `start` yields a full frame beginning with A5.
- Minimum-latency handshake: with `tx_done` returned in the cycle after every `tx_start`, `done` asserts exactly 45 cycles after `start`, and a stray `tx_done` in IDLE produces no output activity.

Source files
------------

// File: rtl/mem_dump_tx_if.sv
// rtl/mem_dump_tx_if.sv - byte handshake between the dump serializer and the UART TX core
interface mem_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;

  modport master (output tx_data, output tx_start, input tx_done);
  modport slave  (input tx_data, input tx_start, output tx_done);
endinterface

// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - frames five snapshot words as header, 20 data bytes and XOR checksum for the UART
module mem_dump_tx #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] memoria0,
  input  logic [31:0] memoria1,
  input  logic [31:0] memoria2,
  input  logic [31:0] memoria3,
  input  logic [31:0] memoria4,
  mem_dump_tx_if.master uart,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [4:0] LAST_DATA_IDX = 5'd20;
  localparam logic [4:0] CSUM_IDX      = 5'd21;

  logic [1:0]   state;
  logic [159:0] snapshot;
  logic [4:0]   idx;
  logic [7:0]   csum;
  logic [7:0]   data_q;

  logic [7:0]   data_bytes [20];
  logic [4:0]   next_idx;
  logic [4:0]   data_sel;
  logic [7:0]   next_byte;

  // Byte k of the snapshot (0..19) is word k/4, most significant byte first.
  always_comb begin
    for (int i = 0; i < 20; i++) begin
      data_bytes[i] = snapshot[159 - 8*i -: 8];
    end
  end

  // The checksum byte is selected only after SEND of byte 20 has folded it in.
  always_comb begin
    next_idx  = idx + 5'd1;
    data_sel  = next_idx - 5'd1;
    next_byte = csum;
    if (next_idx <= LAST_DATA_IDX) begin
      next_byte = data_bytes[data_sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      snapshot <= '0;
      idx      <= '0;
      csum     <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= {memoria0, memoria1, memoria2, memoria3, memoria4};
            idx      <= '0;
            csum     <= '0;
            data_q   <= HEADER;
            state    <= SEND;
          end
        end
        SEND: begin
          if (idx != 5'd0 && idx <= LAST_DATA_IDX) begin
            csum <= csum ^ data_q;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (uart.tx_done) begin
            if (idx == CSUM_IDX) begin
              state <= FINISH;
            end else begin
              idx    <= next_idx;
              data_q <= next_byte;
              state  <= SEND;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign uart.tx_data  = data_q;
  assign uart.tx_start = (state == SEND);
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb/tb_mem_dump_tx.sv - directed self-checking bench for mem_dump_tx with a UART TX handshake model
module tb_mem_dump_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] memoria0, memoria1, memoria2, memoria3, memoria4;
  logic        busy, done;
  logic        model_done, stray_done;

  mem_dump_tx_if u_if ();

  mem_dump_tx #(.HEADER(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .memoria0 (memoria0),
    .memoria1 (memoria1),
    .memoria2 (memoria2),
    .memoria3 (memoria3),
    .memoria4 (memoria4),
    .uart     (u_if.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign u_if.tx_done = model_done | stray_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulses, dones, consec, activity, start_cyc, done_cyc;
  int udelay = 3;
  bit uart_en = 1'b1;
  bit prev_start = 1'b0;
  logic [7:0] rx_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_start = 1'b0;
    end else begin
      if (u_if.tx_start) begin
        rx_q.push_back(u_if.tx_data);
        pulses++;
        if (prev_start) consec++;
      end
      if (u_if.tx_start || busy || done) activity++;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      prev_start = u_if.tx_start;
    end
  end

  // UART model: tx_done is high for one cycle, udelay cycles after the tx_start cycle.
  initial begin
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_en && !reset && u_if.tx_start) begin
        repeat (udelay) @(posedge clk);
        #1 model_done = 1'b1;
        @(posedge clk);
        #1 model_done = 1'b0;
      end
    end
  end

  task automatic set_words(input logic [31:0] w0, w1, w2, w3, w4);
    memoria0 = w0; memoria1 = w1; memoria2 = w2; memoria3 = w3; memoria4 = w4;
  endtask

  task automatic begin_frame();
    rx_q.delete();
    pulses = 0; dones = 0; consec = 0;
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input string tag);
    for (int i = 0; i < 500 && pulses < n; i++) @(negedge clk);
    check({tag, "_reached"}, 32'(pulses >= n), 32'd1);
  endtask

  task automatic end_frame(input string name, input logic [31:0] w0, w1, w2, w3, w4,
                           input logic [7:0] exp_csum);
    logic [159:0] words;
    logic [159:0] sh;
    for (int i = 0; i < 3000 && dones == 0; i++) @(posedge clk);
    #1;
    check({name, "_done_seen"}, 32'(dones != 0), 32'd1);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({name, "_done_1cyc"}, {31'd0, done}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check({name, "_pulses"}, 32'(pulses), 32'd22);
    check({name, "_dones"}, 32'(dones), 32'd1);
    check({name, "_no_b2b"}, 32'(consec), 32'd0);
    check({name, "_nbytes"}, 32'(rx_q.size()), 32'd22);
    if (rx_q.size() == 22) begin
      check({name, "_header"}, {24'd0, rx_q[0]}, 32'hA5);
      words = {w0, w1, w2, w3, w4};
      for (int k = 0; k < 20; k++) begin
        sh = words << (8 * k);
        check($sformatf("%s_byte%0d", name, k + 1), {24'd0, rx_q[k + 1]}, {24'd0, sh[159:152]});
      end
      check({name, "_csum"}, {24'd0, rx_q[21]}, {24'd0, exp_csum});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stray_done = 1'b0;
    set_words(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #1;
    check("rst_tx_data", {24'd0, u_if.tx_data}, 32'd0);
    check("rst_tx_start", {31'd0, u_if.tx_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    set_words(32'h11223344, 32'h55667788, 32'd0, 32'd0, 32'd0);
    begin_frame();
    end_frame("basic", 32'h11223344, 32'h55667788, 32'd0, 32'd0, 32'd0, 8'h88);

    set_words(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    begin_frame();
    end_frame("ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00);

    set_words(32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'd0);
    begin_frame();
    wait_pulses(1, "iso_hdr");
    memoria0 = 32'h0;
    end_frame("iso", 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'd0, 8'h22);

    set_words(32'h01020304, 32'd0, 32'd0, 32'd0, 32'hA0B0C0D0);
    begin_frame();
    wait_pulses(6, "busy_b5");
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    end_frame("busy_start", 32'h01020304, 32'd0, 32'd0, 32'd0, 32'hA0B0C0D0, 8'h04);

    set_words(32'h12345678, 32'h9ABCDEF1, 32'd0, 32'd0, 32'd0);
    begin_frame();
    wait_pulses(8, "rst_b7");
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_tx_data", {24'd0, u_if.tx_data}, 32'd0);
    check("midrst_tx_start", {31'd0, u_if.tx_start}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_no_done", 32'(dones), 32'd0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    begin_frame();
    end_frame("after_rst", 32'h12345678, 32'h9ABCDEF1, 32'd0, 32'd0, 32'd0, 8'h01);

    udelay = 1;
    set_words(32'h0F0F0F0F, 32'h00000080, 32'd0, 32'd0, 32'd0);
    begin_frame();
    end_frame("minlat", 32'h0F0F0F0F, 32'h00000080, 32'd0, 32'd0, 32'd0, 8'h80);
    check("minlat_cycles", 32'(done_cyc - start_cyc), 32'd45);

    uart_en = 1'b0;
    pulses = 0;
    activity = 0;
    @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stray_pulses", 32'(pulses), 32'd0);
    check("stray_activity", 32'(activity), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
